// File: rtl/sdp_ram_pkg.sv
// sdp_ram_pkg: shared types, read-during-write constants and the lane-merge helper for sdp_ram_param
package sdp_ram_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int MAX_W  = 256;
  localparam int MAX_BE = 32;
  function automatic logic [MAX_W-1:0] lane_merge(input logic [MAX_W-1:0] old_w, input logic [MAX_W-1:0] new_w, input logic [MAX_BE-1:0] be, input int lane_w);
    logic [MAX_W-1:0] r;
    logic [MAX_BE-1:0] sh;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      sh = be >> (i / lane_w);
      r[i] = sh[0] ? new_w[i] : old_w[i];
    end
    return r;
  endfunction
endpackage

// File: rtl/sdp_ram_clear_seq.sv
// sdp_ram_clear_seq: post-reset clear sequencer; ports clk, rst in; clr_we, clr_addr, init_busy out
module sdp_ram_clear_seq import sdp_ram_pkg::*; #(
  parameter int ADDR_W        = 10,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_busy
);
  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= (INIT_ON_RESET != 0) ? CLEAR : READY;
      cnt_q   <= '0;
      busy_q  <= (INIT_ON_RESET != 0);
    end else if (state_q == CLEAR) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_q <= READY;
        busy_q  <= 1'b0;
      end
    end
  assign clr_we    = state_q == CLEAR;
  assign clr_addr  = cnt_q;
  assign init_busy = busy_q;
endmodule

// File: rtl/sdp_ram_param.sv
// sdp_ram_param: simple-dual-port RAM with byte lanes, RDW policy, optional output register and post-reset clear
// ports: clk, rst; write port wen_A/be_A/addr_A/din_A; read port ren_B/addr_B -> dout_B/dvalid_B; init_busy
module sdp_ram_param import sdp_ram_pkg::*; #(
  parameter int DATA_W        = 18,
  parameter int ADDR_W        = 10,
  parameter int BE_W          = 2,
  parameter int OUT_REG       = 1,
  parameter int RDW_MODE      = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen_A,
  input  logic [BE_W-1:0]   be_A,
  input  logic [ADDR_W-1:0] addr_A,
  input  logic [DATA_W-1:0] din_A,
  input  logic              ren_B,
  input  logic [ADDR_W-1:0] addr_B,
  output logic [DATA_W-1:0] dout_B,
  output logic              dvalid_B,
  output logic              init_busy
);
  localparam int LANE_W = DATA_W / BE_W;
  localparam int DEPTH  = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              clr_we, we, rd_req, s1_v_q, s2_v_q;
  logic [ADDR_W-1:0] clr_addr, wa;
  logic [BE_W-1:0]   wbe;
  logic [DATA_W-1:0] wd, rd_old, rd_d, s1_q, s2_q;
  sdp_ram_clear_seq #(.ADDR_W(ADDR_W), .INIT_ON_RESET(INIT_ON_RESET)) u_clr (
    .clk(clk), .rst(rst), .clr_we(clr_we), .clr_addr(clr_addr), .init_busy(init_busy)
  );
  // the clear sequencer owns the write port while busy; nothing is written during reset
  always_comb begin
    we     = !rst && (init_busy ? clr_we : wen_A);
    wa     = init_busy ? clr_addr : addr_A;
    wbe    = init_busy ? '1 : be_A;
    wd     = init_busy ? '0 : din_A;
    rd_req = ren_B && !init_busy;
    rd_old = mem_q[addr_B];
    rd_d   = (RDW_MODE == RDW_WRITE_FIRST && wen_A && addr_A == addr_B)
           ? DATA_W'(lane_merge(MAX_W'(rd_old), MAX_W'(din_A), MAX_BE'(be_A), LANE_W)) : rd_old;
  end
  always_ff @(posedge clk)
    if (we) mem_q[wa] <= DATA_W'(lane_merge(MAX_W'(mem_q[wa]), MAX_W'(wd), MAX_BE'(wbe), LANE_W));
  always_ff @(posedge clk)
    if (rst) begin
      s1_q   <= '0;
      s1_v_q <= 1'b0;
      s2_q   <= '0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= rd_req;
      s2_v_q <= s1_v_q;
      if (rd_req) s1_q <= rd_d;
      if (s1_v_q) s2_q <= s1_q;
    end
  assign dout_B   = (OUT_REG != 0) ? s2_q : s1_q;
  assign dvalid_B = (OUT_REG != 0) ? s2_v_q : s1_v_q;
endmodule
